// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - shared constants and event record for input_debouncer
// Default sizing plus the record layout a consumer sees on the event port.
package input_debouncer_pkg;

  localparam int DB_WIDTH    = 8;
  localparam int DB_PRESCALE = 1000;
  localparam int DB_STABLE   = 4;

  typedef struct packed {
    logic [DB_WIDTH-1:0] data;
    logic [DB_WIDTH-1:0] rise;
    logic [DB_WIDTH-1:0] fall;
  } db_event_t;

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// rtl/input_debouncer_debounce_bit.sv - one-bit synchroniser, tick-sampled history and level accept
// The history only advances on tick; a level is accepted once every history bit agrees.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int STABLE = DB_STABLE
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_pin,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  logic              r_sync1;
  logic              r_sync2;
  logic [STABLE-1:0] r_hist;
  logic              r_db;
  logic              r_rise;
  logic              r_fall;
  logic              w_all1;
  logic              w_all0;

  assign w_all1 = &r_hist;
  assign w_all0 = ~|r_hist;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        r_hist <= {r_hist[STABLE-2:0], r_sync2};
      end
      // Pulses are registered alongside r_db so they coincide with the level change.
      r_rise <= w_all1 && !r_db;
      r_fall <= w_all0 && r_db;
      if (w_all1) begin
        r_db <= 1'b1;
      end else if (w_all0) begin
        r_db <= 1'b0;
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - input byte debouncer with prescaled sampling and valid/ready change events
// EVENT_OVERRUN_EN: keep the pending event on conflict and raise sticky evt_ovr; otherwise latest wins.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH    = DB_WIDTH,
  parameter int PRESCALE = DB_PRESCALE,
  parameter int STABLE   = DB_STABLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_rise,
  output logic [WIDTH-1:0] evt_fall,
  output logic             evt_ovr,
  input  logic             ovr_clr
);

  localparam int              CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(PRESCALE - 1);

  logic [CW-1:0]    r_cnt;
  logic             w_tick;
  logic             w_change;
  logic             w_take;
  logic             w_conflict;
  logic             w_load;
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_data;
  logic [WIDTH-1:0] r_evt_rise;
  logic [WIDTH-1:0] r_evt_fall;

  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(.STABLE(STABLE)) u_bit (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_tick (w_tick),
      .i_pin  (pin_in[g]),
      .o_db   (db_out[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

  assign w_change   = |(rise | fall);
  assign w_take     = w_change && (!r_evt_valid || evt_ready);
  assign w_conflict = w_change && r_evt_valid && !evt_ready;

`ifdef EVENT_OVERRUN_EN
  logic r_ovr;

  assign w_load = w_take;

  // A fresh overrun beats a simultaneous clear so no loss goes unreported.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 1'b0;
    end else if (w_conflict) begin
      r_ovr <= 1'b1;
    end else if (ovr_clr) begin
      r_ovr <= 1'b0;
    end
  end

  assign evt_ovr = r_ovr;
`else
  logic w_unused_ovr;

  assign w_load       = w_change;
  assign w_unused_ovr = &{1'b0, ovr_clr, w_take, w_conflict};
  assign evt_ovr      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_evt_rise  <= '0;
      r_evt_fall  <= '0;
    end else if (w_load) begin
      r_evt_valid <= 1'b1;
      r_evt_data  <= db_out;
      r_evt_rise  <= rise;
      r_evt_fall  <= fall;
    end else if (w_change) begin
      r_evt_valid <= r_evt_valid;
    end else if (evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_data  = r_evt_data;
  assign evt_rise  = r_evt_rise;
  assign evt_fall  = r_evt_fall;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - randomized and directed bench for input_debouncer against a sample-list model
module tb_input_debouncer;
  import input_debouncer_pkg::*;

  localparam int S    = 4;
  localparam int MAXE = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin, pin2;
  logic       evt_ready, ovr_clr;

  logic [7:0] db_o [2];
  logic [7:0] rise_o [2];
  logic [7:0] fall_o [2];
  logic [7:0] evd [2];
  logic [7:0] evr [2];
  logic [7:0] evf [2];
  logic       ev_v [2];
  logic       ovr_o [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  input_debouncer #(.WIDTH(8), .PRESCALE(1), .STABLE(S)) u_dut_p1 (
    .clk(clk), .rst(rst), .pin_in(pin), .db_out(db_o[0]), .rise(rise_o[0]), .fall(fall_o[0]),
    .evt_valid(ev_v[0]), .evt_ready(evt_ready), .evt_data(evd[0]), .evt_rise(evr[0]),
    .evt_fall(evf[0]), .evt_ovr(ovr_o[0]), .ovr_clr(ovr_clr));

  input_debouncer #(.WIDTH(8), .PRESCALE(10), .STABLE(S)) u_dut_p10 (
    .clk(clk), .rst(rst), .pin_in(pin2), .db_out(db_o[1]), .rise(rise_o[1]), .fall(fall_o[1]),
    .evt_valid(ev_v[1]), .evt_ready(evt_ready), .evt_data(evd[1]), .evt_rise(evr[1]),
    .evt_fall(evf[1]), .evt_ovr(ovr_o[1]), .ovr_clr(ovr_clr));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: db after edge m depends on the last S tick samples taken up to edge m-1;
  // tick edges are the positive multiples of P, each sampling the pin seen two edges earlier.
  int         me = 0;
  int         ps [2] = '{1, 10};
  logic [7:0] plog [2][MAXE];
  logic [7:0] mdb [2], mrise [2], mfall [2];
  logic       mv [2], movr [2];
  db_event_t  mev [2];

  always @(posedge clk) begin
    logic       chg, conflict;
    logic [7:0] ones, zeros, s, nd;
    int         t0, e;
    if (rst) begin
      me = 0;
      for (int i = 0; i < 2; i++) begin
        mdb[i] = 0; mrise[i] = 0; mfall[i] = 0; mv[i] = 0; movr[i] = 0; mev[i] = '0;
      end
    end else begin
      me++;
      plog[0][me] = pin;
      plog[1][me] = pin2;
      for (int i = 0; i < 2; i++) begin
        chg      = |(mrise[i] | mfall[i]);
        conflict = chg && mv[i] && !evt_ready;
        if (chg && (!mv[i] || evt_ready)) begin
          mv[i]  = 1'b1;
          mev[i] = '{data: mdb[i], rise: mrise[i], fall: mfall[i]};
        end else if (chg) begin
`ifndef EVENT_OVERRUN_EN
          mev[i] = '{data: mdb[i], rise: mrise[i], fall: mfall[i]};
`endif
        end else if (evt_ready) begin
          mv[i] = 1'b0;
        end
`ifdef EVENT_OVERRUN_EN
        if (conflict) movr[i] = 1'b1;
        else if (ovr_clr) movr[i] = 1'b0;
`endif
        ones  = 8'hFF;
        zeros = 8'hFF;
        t0    = ((me - 1) / ps[i]) * ps[i];
        for (int j = 0; j < S; j++) begin
          e = t0 - j * ps[i];
          s = (e - 2 >= 1) ? plog[i][e-2] : 8'h00;
          ones  &= s;
          zeros &= ~s;
        end
        nd       = (mdb[i] & ~zeros) | ones;
        mrise[i] = nd & ~mdb[i];
        mfall[i] = ~nd & mdb[i];
        mdb[i]   = nd;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i == 0 ? "cycle_p1" : "cycle_p10",
          {14'd0, db_o[i], rise_o[i], fall_o[i], ev_v[i], evd[i], evr[i], evf[i], ovr_o[i]},
          {14'd0, mdb[i], mrise[i], mfall[i], mv[i], mev[i].data, mev[i].rise, mev[i].fall, movr[i]});
    end
  end

  task automatic to_edge(input int t);
    int k = 0;
    while (me < t && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (me != t) begin
      tests++;
      fails++;
      $display("FAIL to_edge: actual=%0d required=%0d", me, t);
    end
  endtask

  // PRESCALE=10 step on bit7, present from the first post-reset edge.
  initial begin : p10_step
    int k = 0;
    @(negedge rst);
    while (me < 40 && k < 1000) begin @(negedge clk); k++; end
    chk("p10_db_edge40", db_o[1], 8'h00);
    @(negedge clk);
    chk("p10_db_edge41", db_o[1], 8'h80);
    chk("p10_rise_edge41", rise_o[1], 8'h80);
  end

  initial begin : tick_meas
    int last = -1, cyc = 0, n = 0;
    @(negedge rst);
    while (n < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (u_dut_p10.w_tick) begin
        if (last >= 0) begin
          chk("tick_period", 64'(cyc - last), 64'd10);
          n++;
        end
        last = cyc;
      end
    end
    if (n < 4) chk("tick_seen", 64'(n), 64'd4);
  end

  initial begin
    logic bad;
    int   hold;
    rst = 1'b1; pin = 8'hFF; pin2 = 8'h80; evt_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_p1", {db_o[0], rise_o[0], fall_o[0], evd[0], evr[0], evf[0], ev_v[0], ovr_o[0]}, 64'd0);
    chk("reset_outs_p10", {db_o[1], rise_o[1], fall_o[1], evd[1], evr[1], evf[1], ev_v[1], ovr_o[1]}, 64'd0);
    rst = 1'b0;

    to_edge(6);  chk("db_before_latency", db_o[0], 8'h00);
    to_edge(7);  chk("db_at_latency", db_o[0], 8'hFF);
                 chk("rise_at_latency", rise_o[0], 8'hFF);
    to_edge(8);  chk("rise_one_cycle", rise_o[0], 8'h00);
                 chk("first_event", {ev_v[0], evd[0], evr[0]}, {1'b1, 8'hFF, 8'hFF});
    evt_ready = 1'b1;
    to_edge(9);  chk("accept_clears_valid", ev_v[0], 1'b0);
    evt_ready = 1'b0;

    pin = 8'hFE;
    to_edge(12);
    pin = 8'hFF;
    bad = 1'b0;
    while (me < 24) begin
      @(negedge clk);
      if (db_o[0] !== 8'hFF || ev_v[0] !== 1'b0 || fall_o[0] !== 8'h00) bad = 1'b1;
    end
    chk("glitch_rejected", bad, 1'b0);

    pin = 8'h00; evt_ready = 1'b1;
    to_edge(34);
    evt_ready = 1'b0;
    chk("drain_to_zero", {db_o[0], ev_v[0]}, {8'h00, 1'b0});
    pin = 8'h05;
    to_edge(44); chk("hs_event", {ev_v[0], evd[0], evr[0], evf[0]}, {1'b1, 8'h05, 8'h05, 8'h00});
    to_edge(47); chk("hs_stable", {ev_v[0], evd[0], evr[0], evf[0]}, {1'b1, 8'h05, 8'h05, 8'h00});

    pin = 8'h04;
    to_edge(54); chk("b2b_pending", {ev_v[0], evd[0]}, {1'b1, 8'h05});
    evt_ready = 1'b1;
    to_edge(55);
    evt_ready = 1'b0;
    chk("b2b_event", {ev_v[0], evd[0], evr[0], evf[0]}, {1'b1, 8'h04, 8'h00, 8'h01});

    pin = 8'h06;
    to_edge(65);
    pin = 8'h07;
    to_edge(76);
`ifdef EVENT_OVERRUN_EN
    chk("ovr_keep", {ev_v[0], evd[0], evf[0], ovr_o[0]}, {1'b1, 8'h04, 8'h01, 1'b1});
`else
    chk("ovr_overwrite", {ev_v[0], evd[0], evr[0], evf[0], ovr_o[0]}, {1'b1, 8'h07, 8'h01, 8'h00, 1'b0});
`endif
    ovr_clr = 1'b1;
    to_edge(77);
    ovr_clr = 1'b0;
    chk("ovr_cleared", {ev_v[0], ovr_o[0]}, {1'b1, 1'b0});

    for (int ph = 0; ph < 120; ph++) begin
      if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
      else pin = pin ^ (8'h01 << $urandom_range(0, 7));
      pin2 = pin;
      hold = $urandom_range(1, 50);
      if (ph == 60) rst = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        rst       = 1'b0;
        evt_ready = ($urandom_range(0, 2) == 0);
        ovr_clr   = ($urandom_range(0, 9) == 0);
      end
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
